binary_to_bcd_seq: RTL and testbench

Sequential, parametrised binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm. It is the successor to the 5-bit combinational tens/units converter. It accepts any unsigned `WIDTH`-bit value and produces `DIGITS` packed BCD digits through a start/ready/done handshake. It sits between the binary datapath and the 7-segment display drivers; the converted result is held stable for the display until the next conversion completes.

---
 rtl/binary_to_bcd_seq.sv | 106 ++++++++++
 tb/tb_binary_to_bcd_seq.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/binary_to_bcd_seq.sv
// Sequential binary-to-BCD converter using shift-and-add-3 (double dabble).
// One bit per cycle; the result is held in bcd until the next conversion completes.
module binary_to_bcd_seq #(
  parameter int WIDTH  = 5,
  parameter int DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      Nb,
  output logic                  ready,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int BW = 4 * DIGITS;
  localparam int SW = BW + WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  function automatic longint pow10(input int n);
    longint p;
    p = 1;
    for (int i = 0; i < n && i < 18; i++) p = p * 10;
    return p;
  endfunction

  localparam longint MAXV = (longint'(1) << WIDTH) - 1;

  generate
    if (pow10(DIGITS) <= MAXV) begin : g_bad_digits
      $warning("binary_to_bcd_seq: DIGITS too small for WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t        state;
  logic [SW-1:0] sr;
  logic [SW-1:0] sr_adj;
  logic [CW-1:0] cnt;

  always_comb begin
    sr_adj = sr;
    for (int i = 0; i < DIGITS; i++) begin
      if (sr[WIDTH+4*i +: 4] >= 4'd5)
        sr_adj[WIDTH+4*i +: 4] = sr[WIDTH+4*i +: 4] + 4'd3;
    end
  end

  // DONE keeps ready high so a held start restarts every WIDTH+2 cycles
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
      sr    <= '0;
      cnt   <= '0;
      ready <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
      bcd   <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            sr    <= {{BW{1'b0}}, Nb};
            cnt   <= '0;
            ready <= 1'b0;
            busy  <= 1'b1;
            state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (cnt == CW'(WIDTH)) begin
            bcd   <= sr[SW-1 -: BW];
            done  <= 1'b1;
            busy  <= 1'b0;
            ready <= 1'b1;
            state <= S_DONE;
          end else begin
            sr  <= sr_adj << 1;
            cnt <= cnt + CW'(1);
          end
        end
        S_DONE: begin
          done <= 1'b0;
          if (start) begin
            sr    <= {{BW{1'b0}}, Nb};
            cnt   <= '0;
            ready <= 1'b0;
            busy  <= 1'b1;
            state <= S_SHIFT;
          end else begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_binary_to_bcd_seq.sv
// Self-checking bench for binary_to_bcd_seq: default and 8-bit/3-digit instances
// checked against a decimal-arithmetic reference model.
module tb_binary_to_bcd_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, start_w;
  logic [4:0]  nb;
  logic [7:0]  nb_w;
  logic        ready, busy, done;
  logic        ready_w, busy_w, done_w;
  logic [7:0]  bcd;
  logic [11:0] bcd_w;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  binary_to_bcd_seq dut (
    .clk(clk), .reset(reset), .start(start), .Nb(nb),
    .ready(ready), .busy(busy), .done(done), .bcd(bcd)
  );

  binary_to_bcd_seq #(.WIDTH(8), .DIGITS(3)) dut_w (
    .clk(clk), .reset(reset), .start(start_w), .Nb(nb_w),
    .ready(ready_w), .busy(busy_w), .done(done_w), .bcd(bcd_w)
  );

  function automatic logic [11:0] ref_bcd(input int v, input int digits);
    logic [11:0] r;
    r = '0;
    for (int i = 0; i < digits; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic conv(input logic [4:0] v, output logic [7:0] res,
                      output int lat);
    int w;
    lat = -1;
    res = 'x;
    w = 0;
    while (!ready && w < 20) begin tick(); w++; end
    if (!ready) return;
    start = 1'b1;
    nb = v;
    tick();
    start = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (done) begin lat = n; res = bcd; return; end
    end
  endtask

  task automatic conv_w(input logic [7:0] v, output logic [11:0] res,
                        output int lat);
    int w;
    lat = -1;
    res = 'x;
    w = 0;
    while (!ready_w && w < 20) begin tick(); w++; end
    if (!ready_w) return;
    start_w = 1'b1;
    nb_w = v;
    tick();
    start_w = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (done_w) begin lat = n; res = bcd_w; return; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start = 1'b0;
    start_w = 1'b0;
    nb = '0;
    nb_w = '0;
    tick();
    tick();
    reset = 1'b1;
    for (int c = 0; c < 11; c++) begin
      checks++;
      if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || bcd !== 8'h00) begin
        errors++;
        $display("FAIL reset_idle c=%0d got r=%b b=%b d=%b bcd=%h want 1 0 0 00",
                 c, ready, busy, done, bcd);
      end
      checks++;
      if (ready_w !== 1'b1 || busy_w !== 1'b0 || done_w !== 1'b0 || bcd_w !== 12'h000) begin
        errors++;
        $display("FAIL reset_idle_w c=%0d got r=%b b=%b d=%b bcd=%h want 1 0 0 000",
                 c, ready_w, busy_w, done_w, bcd_w);
      end
      tick();
    end
  endtask

  task automatic test_sweep();
    int          vals[11] = '{0, 31, 21, 24, 22, 25, 13, 14, 28, 30, 11};
    logic [7:0]  exp[11]  = '{8'h00, 8'h31, 8'h21, 8'h24, 8'h22, 8'h25,
                              8'h13, 8'h14, 8'h28, 8'h30, 8'h11};
    logic [7:0]  r;
    int          lat;
    for (int i = 0; i < 11; i++) begin
      conv(5'(vals[i]), r, lat);
      checks++;
      if (r !== exp[i] || lat != 6) begin
        errors++;
        $display("FAIL sweep nb=%0d got bcd=%h lat=%0d want bcd=%h lat=6",
                 vals[i], r, lat, exp[i]);
      end
    end
    for (int v = 0; v < 32; v++) begin
      conv(5'(v), r, lat);
      checks++;
      if (r !== ref_bcd(v, 2)[7:0] || lat != 6) begin
        errors++;
        $display("FAIL exhaustive nb=%0d got bcd=%h lat=%0d want bcd=%h lat=6",
                 v, r, lat, ref_bcd(v, 2)[7:0]);
      end
    end
  endtask

  task automatic test_handshake();
    int w;
    w = 0;
    while (!ready && w < 20) begin tick(); w++; end
    start = 1'b1;
    nb = 5'd27;
    tick();
    start = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      tick();
      if (e == 1) begin
        start = 1'b1;
        nb = 5'd9;
      end else if (e == 2) begin
        start = 1'b0;
        nb = 5'd13;
      end
      if (e >= 1 && e <= 4) begin
        checks++;
        if (busy !== 1'b1 || ready !== 1'b0) begin
          errors++;
          $display("FAIL hs_busy e=%0d got b=%b r=%b want 1 0", e, busy, ready);
        end
      end
      checks++;
      if (done !== (e == 6)) begin
        errors++;
        $display("FAIL hs_done e=%0d got %b want %b", e, done, (e == 6));
      end
      if (e == 6) begin
        checks++;
        if (bcd !== 8'h27 || ready !== 1'b1) begin
          errors++;
          $display("FAIL hs_result got bcd=%h r=%b want 27 1", bcd, ready);
        end
      end
    end
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++;
      if (done !== 1'b0 || bcd !== 8'h27) begin
        errors++;
        $display("FAIL hs_ignored c=%0d got d=%b bcd=%h want 0 27", c, done, bcd);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] r;
    int         lat;
    start = 1'b1;
    nb = 5'd19;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    checks++;
    if (done !== 1'b0 || bcd !== 8'h00 || ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid got d=%b bcd=%h r=%b b=%b want 0 00 1 0",
               done, bcd, ready, busy);
    end
    for (int c = 0; c < 8; c++) begin
      tick();
      checks++;
      if (done !== 1'b0 || bcd !== 8'h00) begin
        errors++;
        $display("FAIL rst_quiet c=%0d got d=%b bcd=%h want 0 00", c, done, bcd);
      end
    end
    conv(5'd19, r, lat);
    checks++;
    if (r !== 8'h19 || lat != 6) begin
      errors++;
      $display("FAIL rst_restart got bcd=%h lat=%0d want 19 6", r, lat);
    end
  endtask

  task automatic test_wide();
    int          vals[4] = '{255, 100, 99, 0};
    logic [11:0] exp[4]  = '{12'h255, 12'h100, 12'h099, 12'h000};
    logic [11:0] r;
    int          lat;
    int          v;
    for (int i = 0; i < 4; i++) begin
      conv_w(8'(vals[i]), r, lat);
      checks++;
      if (r !== exp[i] || lat != 9) begin
        errors++;
        $display("FAIL wide nb=%0d got bcd=%h lat=%0d want bcd=%h lat=9",
                 vals[i], r, lat, exp[i]);
      end
    end
    for (int i = 0; i < 20; i++) begin
      v = int'($urandom_range(255, 0));
      conv_w(8'(v), r, lat);
      checks++;
      if (r !== ref_bcd(v, 3) || lat != 9) begin
        errors++;
        $display("FAIL wide_rand nb=%0d got bcd=%h lat=%0d want bcd=%h lat=9",
                 v, r, lat, ref_bcd(v, 3));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] nbs[$];
    int         w;
    int         ndone;
    w = 0;
    while (!ready && w < 20) begin tick(); w++; end
    ndone = 0;
    for (int e = 0; e < 45; e++) begin
      nb = 5'($urandom_range(31, 0));
      nbs.push_back(nb);
      start = 1'b1;
      tick();
      checks++;
      if (done !== (e % 7 == 6)) begin
        errors++;
        $display("FAIL b2b_done e=%0d got %b want %b", e, done, (e % 7 == 6));
      end
      if (done === 1'b1 && e >= 6) begin
        ndone++;
        checks++;
        if (bcd !== ref_bcd(int'(nbs[e-6]), 2)[7:0]) begin
          errors++;
          $display("FAIL b2b_result e=%0d nb=%0d got %h want %h",
                   e, nbs[e-6], bcd, ref_bcd(int'(nbs[e-6]), 2)[7:0]);
        end
      end
    end
    start = 1'b0;
    checks++;
    if (ndone != 6) begin
      errors++;
      $display("FAIL b2b_count got %0d want 6", ndone);
    end
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_handshake();
    test_reset_mid();
    test_wide();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
